dpd_capture_ctrl: RTL and testbench

//  Downstream of gva_ctrl: consumes its adapt_out window and captures paired
//  TX reference (PA input) and feedback-receiver (PA output) I/Q samples into a

---
 rtl/dpd_capture_if.sv | 45 ++++
 rtl/dpd_capture_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dpd_capture_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dpd_capture_if.sv
// Capture-controller bus: window/sample inputs, buffer read port and status.
// Port i_ref_dly exists only when FB_ALIGN_EN is defined.
interface dpd_capture_if #(
    parameter int DW    = 16,
    parameter int AW    = 10,
    parameter int DLY_W = 6
);
    logic                 i_adapt_win;
    logic                 i_s_valid;
    logic signed [DW-1:0] i_ref_i;
    logic signed [DW-1:0] i_ref_q;
    logic signed [DW-1:0] i_fb_i;
    logic signed [DW-1:0] i_fb_q;
`ifdef FB_ALIGN_EN
    logic [DLY_W-1:0]     i_ref_dly;
`endif
    logic                 i_rd_en;
    logic [AW-1:0]        i_rd_addr;
    logic [2*DW-1:0]      o_rd_ref;
    logic [2*DW-1:0]      o_rd_fb;
    logic                 i_rd_release;
    logic                 o_busy;
    logic                 o_buf_valid;
    logic                 o_cap_done;
    logic                 o_cap_abort;
    logic [7:0]           o_miss_cnt;

    modport master (
        output i_adapt_win, i_s_valid, i_ref_i, i_ref_q, i_fb_i, i_fb_q,
`ifdef FB_ALIGN_EN
        output i_ref_dly,
`endif
        output i_rd_en, i_rd_addr, i_rd_release,
        input  o_rd_ref, o_rd_fb, o_busy, o_buf_valid, o_cap_done, o_cap_abort, o_miss_cnt
    );

    modport slave (
        input  i_adapt_win, i_s_valid, i_ref_i, i_ref_q, i_fb_i, i_fb_q,
`ifdef FB_ALIGN_EN
        input  i_ref_dly,
`endif
        input  i_rd_en, i_rd_addr, i_rd_release,
        output o_rd_ref, o_rd_fb, o_busy, o_buf_valid, o_cap_done, o_cap_abort, o_miss_cnt
    );
endinterface

// File: rtl/dpd_capture_ctrl.sv
// DPD capture controller: skips SKIP settling samples after the window opens, fills a
// DEPTH-pair ref/fb buffer, then locks it until released. FB_ALIGN_EN adds a ref delay line.
module dpd_capture_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 10,
    parameter int SKIP  = 64,
    parameter int DLY_W = 6
) (
    input  logic         clk,
    input  logic         reset_b,
    dpd_capture_if.slave bus
);
    localparam int          DEPTH     = 2**AW;
    localparam logic [15:0] SKIP_LAST = (SKIP > 0) ? 16'(SKIP - 1) : 16'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_CAPT, ST_HOLD} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_win_d;
    logic                 w_open;
    logic [AW-1:0]        r_wr_ptr;
    logic [15:0]          r_skip_cnt;
    logic                 r_cap_done;
    logic                 r_cap_abort;
    logic [7:0]           r_miss_cnt;
    logic                 w_start;
    logic                 w_wr_en;
    logic                 w_skip_inc;
    logic                 w_done;
    logic                 w_abort;
    logic signed [DW-1:0] w_ref_i;
    logic signed [DW-1:0] w_ref_q;
    logic [2*DW-1:0]      r_mem_ref [DEPTH];
    logic [2*DW-1:0]      r_mem_fb  [DEPTH];
    logic [2*DW-1:0]      r_rd_ref;
    logic [2*DW-1:0]      r_rd_fb;

    assign w_open = bus.i_adapt_win & ~r_win_d;

`ifdef FB_ALIGN_EN
    localparam int DLY_N = 2**DLY_W - 1;

    // Entry 0 holds the previous valid sample; the line runs in every state.
    logic signed [DW-1:0] r_dly_i [DLY_N];
    logic signed [DW-1:0] r_dly_q [DLY_N];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int j = 0; j < DLY_N; j++) begin
                r_dly_i[j] <= '0;
                r_dly_q[j] <= '0;
            end
        end else if (bus.i_s_valid) begin
            r_dly_i[0] <= bus.i_ref_i;
            r_dly_q[0] <= bus.i_ref_q;
            for (int j = 1; j < DLY_N; j++) begin
                r_dly_i[j] <= r_dly_i[j-1];
                r_dly_q[j] <= r_dly_q[j-1];
            end
        end
    end

    always_comb begin
        w_ref_i = bus.i_ref_i;
        w_ref_q = bus.i_ref_q;
        if (bus.i_ref_dly != '0) begin
            w_ref_i = r_dly_i[bus.i_ref_dly - DLY_W'(1)];
            w_ref_q = r_dly_q[bus.i_ref_dly - DLY_W'(1)];
        end
    end
`else
    assign w_ref_i = bus.i_ref_i;
    assign w_ref_q = bus.i_ref_q;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_wr_en     = 1'b0;
        w_skip_inc  = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_open) begin
                    w_start     = 1'b1;
                    w_state_nxt = (SKIP == 0) ? ST_CAPT : ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (!bus.i_adapt_win) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (bus.i_s_valid) begin
                    if (r_skip_cnt == SKIP_LAST) w_state_nxt = ST_CAPT;
                    else                         w_skip_inc  = 1'b1;
                end
            end
            ST_CAPT: begin
                if (!bus.i_adapt_win) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (bus.i_s_valid) begin
                    w_wr_en = 1'b1;
                    if (&r_wr_ptr) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.i_rd_release) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_win_d     <= 1'b0;
            r_wr_ptr    <= '0;
            r_skip_cnt  <= '0;
            r_cap_done  <= 1'b0;
            r_cap_abort <= 1'b0;
            r_miss_cnt  <= '0;
        end else begin
            r_win_d     <= bus.i_adapt_win;
            r_cap_done  <= w_done;
            r_cap_abort <= w_abort;
            if (w_start) begin
                r_wr_ptr   <= '0;
                r_skip_cnt <= '0;
            end else begin
                if (w_wr_en)    r_wr_ptr   <= r_wr_ptr + 1'b1;
                if (w_skip_inc) r_skip_cnt <= r_skip_cnt + 1'b1;
            end
            // An opening seen outside IDLE is lost, even when a release exits HOLD.
            if (w_open && (r_state != ST_IDLE) && (r_miss_cnt != 8'hFF))
                r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_ref[r_wr_ptr] <= {w_ref_i, w_ref_q};
            r_mem_fb[r_wr_ptr]  <= {bus.i_fb_i, bus.i_fb_q};
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_rd_ref <= '0;
            r_rd_fb  <= '0;
        end else if (bus.i_rd_en) begin
            r_rd_ref <= r_mem_ref[bus.i_rd_addr];
            r_rd_fb  <= r_mem_fb[bus.i_rd_addr];
        end
    end

    assign bus.o_rd_ref    = r_rd_ref;
    assign bus.o_rd_fb     = r_rd_fb;
    assign bus.o_busy      = (r_state == ST_SKIP) || (r_state == ST_CAPT);
    assign bus.o_buf_valid = (r_state == ST_HOLD);
    assign bus.o_cap_done  = r_cap_done;
    assign bus.o_cap_abort = r_cap_abort;
    assign bus.o_miss_cnt  = r_miss_cnt;
endmodule

// File: tb/tb_dpd_capture_ctrl.sv
// Directed bench for dpd_capture_ctrl (AW=4, SKIP=2, DW=16); FB_ALIGN_EN adds the ref delay check.
module tb_dpd_capture_ctrl;
    logic clk = 1'b0;
    logic reset_b = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   align_mode = 0;
    int   done_at;
    int   done_cnt;

    always #5 clk = ~clk;

    dpd_capture_if #(.DW(16), .AW(4), .DLY_W(6)) bus ();

    dpd_capture_ctrl #(.DW(16), .AW(4), .SKIP(2), .DLY_W(6)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_sample(input int n);
        if (align_mode != 0) begin
            bus.i_ref_i = 16'(n);
            bus.i_fb_i  = 16'(n);
            bus.i_ref_q = 16'(n + 1000);
            bus.i_fb_q  = 16'(n + 1000);
        end else begin
            bus.i_ref_i = 16'(n);
            bus.i_ref_q = 16'(100 + n);
            bus.i_fb_i  = 16'(200 + n);
            bus.i_fb_q  = 16'(300 + n);
        end
    endtask

    // Opens the window, offers 18 valid samples one every 'gap' cycles, then closes it.
    task automatic capture(input int gap, output int d_at, output int d_cnt);
        d_at  = -1;
        d_cnt = 0;
        bus.i_adapt_win = 1'b1;
        tick();
        for (int c = 0; c < 18 * gap + 4; c++) begin
            bus.i_s_valid = ((c % gap) == 0) && ((c / gap) < 18);
            set_sample(c / gap);
            tick();
            if (bus.o_cap_done === 1'b1) begin
                d_cnt++;
                if (d_at < 0) d_at = c;
            end
        end
        bus.i_s_valid   = 1'b0;
        bus.i_adapt_win = 1'b0;
        tick();
    endtask

    task automatic rd_chk(input int a, input logic [31:0] er, input logic [31:0] ef);
        bus.i_rd_en   = 1'b1;
        bus.i_rd_addr = 4'(a);
        tick();
        bus.i_rd_en   = 1'b0;
        chk($sformatf("rd_ref[%0d]", a), bus.o_rd_ref, er);
        chk($sformatf("rd_fb[%0d]", a), bus.o_rd_fb, ef);
    endtask

    task automatic release_buf();
        bus.i_rd_release = 1'b1;
        tick();
        bus.i_rd_release = 1'b0;
    endtask

    task automatic toggle_win(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            bus.i_adapt_win = 1'b1;
            tick();
            bus.i_adapt_win = 1'b0;
            tick();
        end
    endtask

    initial begin
        bus.i_adapt_win  = 1'b0;
        bus.i_s_valid    = 1'b0;
        bus.i_rd_en      = 1'b0;
        bus.i_rd_addr    = '0;
        bus.i_rd_release = 1'b0;
        set_sample(0);
`ifdef FB_ALIGN_EN
        bus.i_ref_dly = '0;
`endif
        repeat (3) tick();
        reset_b = 1'b1;
        tick();

        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_buf_valid", 32'(bus.o_buf_valid), 32'd0);
        chk("rst_cap_done", 32'(bus.o_cap_done), 32'd0);
        chk("rst_cap_abort", 32'(bus.o_cap_abort), 32'd0);
        chk("rst_miss_cnt", 32'(bus.o_miss_cnt), 32'd0);
        chk("rst_rd_ref", bus.o_rd_ref, 32'd0);

        // Back-to-back samples
        capture(1, done_at, done_cnt);
        chk("t1_done_at", 32'(done_at), 32'd17);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_buf_valid", 32'(bus.o_buf_valid), 32'd1);
        chk("t1_busy", 32'(bus.o_busy), 32'd0);
        for (int k = 0; k < 16; k++)
            rd_chk(k, {16'(k + 2), 16'(102 + k)}, {16'(202 + k), 16'(302 + k)});

        // One valid every third cycle
        release_buf();
        chk("t2_idle", 32'(bus.o_buf_valid), 32'd0);
        capture(3, done_at, done_cnt);
        chk("t2_done_at", 32'(done_at), 32'd51);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        chk("t2_buf_valid", 32'(bus.o_buf_valid), 32'd1);
        rd_chk(0, {16'd2, 16'd102}, {16'd202, 16'd302});
        rd_chk(7, {16'd9, 16'd109}, {16'd209, 16'd309});
        rd_chk(15, {16'd17, 16'd117}, {16'd217, 16'd317});

        // Window closes after five captured samples
        release_buf();
        bus.i_adapt_win = 1'b1;
        tick();
        for (int n = 0; n < 7; n++) begin
            bus.i_s_valid = 1'b1;
            set_sample(n);
            tick();
        end
        chk("t3_busy_before", 32'(bus.o_busy), 32'd1);
        bus.i_adapt_win = 1'b0;
        set_sample(7);
        tick();
        bus.i_s_valid = 1'b0;
        chk("t3_abort", 32'(bus.o_cap_abort), 32'd1);
        chk("t3_done", 32'(bus.o_cap_done), 32'd0);
        chk("t3_busy", 32'(bus.o_busy), 32'd0);
        chk("t3_buf_valid", 32'(bus.o_buf_valid), 32'd0);
        tick();
        chk("t3_abort_pulse", 32'(bus.o_cap_abort), 32'd0);

        // Window openings during HOLD are counted, not acted on
        capture(1, done_at, done_cnt);
        toggle_win(3);
        chk("t4_miss3", 32'(bus.o_miss_cnt), 32'd3);
        chk("t4_hold", 32'(bus.o_buf_valid), 32'd1);
        release_buf();
        chk("t4_released", 32'(bus.o_buf_valid), 32'd0);
        chk("t4_miss_keep", 32'(bus.o_miss_cnt), 32'd3);
        capture(1, done_at, done_cnt);
        chk("t4_recap_done_at", 32'(done_at), 32'd17);
        chk("t4_recap_valid", 32'(bus.o_buf_valid), 32'd1);

        // Opening and release in the same HOLD cycle
        bus.i_adapt_win  = 1'b1;
        bus.i_rd_release = 1'b1;
        tick();
        bus.i_rd_release = 1'b0;
        chk("t5_buf_valid", 32'(bus.o_buf_valid), 32'd0);
        chk("t5_busy", 32'(bus.o_busy), 32'd0);
        chk("t5_miss", 32'(bus.o_miss_cnt), 32'd4);
        tick();
        tick();
        chk("t5_no_start", 32'(bus.o_busy), 32'd0);
        chk("t5_miss_keep", 32'(bus.o_miss_cnt), 32'd4);
        bus.i_adapt_win = 1'b0;
        tick();

        // Saturation of the miss counter
        capture(1, done_at, done_cnt);
        toggle_win(200);
        chk("t4_miss204", 32'(bus.o_miss_cnt), 32'd204);
        toggle_win(100);
        chk("t4_miss_sat", 32'(bus.o_miss_cnt), 32'd255);
        release_buf();

        // Asynchronous reset in the middle of CAPT
        bus.i_adapt_win = 1'b1;
        tick();
        for (int n = 0; n < 6; n++) begin
            bus.i_s_valid = 1'b1;
            set_sample(n);
            tick();
        end
        chk("rst_mid_busy_pre", 32'(bus.o_busy), 32'd1);
        #2;
        reset_b = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_mid_miss", 32'(bus.o_miss_cnt), 32'd0);
        chk("rst_mid_rd_ref", bus.o_rd_ref, 32'd0);
        chk("rst_mid_rd_fb", bus.o_rd_fb, 32'd0);
        chk("rst_mid_abort", 32'(bus.o_cap_abort), 32'd0);
        tick();
        chk("rst_mid_no_abort", 32'(bus.o_cap_abort), 32'd0);
        chk("rst_mid_no_done", 32'(bus.o_cap_done), 32'd0);
        bus.i_s_valid   = 1'b0;
        bus.i_adapt_win = 1'b0;
        reset_b = 1'b1;
        tick();

`ifdef FB_ALIGN_EN
        // ref delayed by five valid samples relative to fb
        align_mode    = 1;
        bus.i_ref_dly = 6'd5;
        capture(1, done_at, done_cnt);
        chk("t6_done_at", 32'(done_at), 32'd17);
        rd_chk(0, 32'd0, {16'd2, 16'd1002});
        rd_chk(3, {16'd0, 16'd1000}, {16'd5, 16'd1005});
        rd_chk(10, {16'd7, 16'd1007}, {16'd12, 16'd1012});
        rd_chk(15, {16'd12, 16'd1012}, {16'd17, 16'd1017});
        release_buf();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
